// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the DLX pipeline. Issues word loads/stores to the
// data memory over a request/acknowledge bus, stalls the pipeline while the
// memory inserts wait states, aborts accesses that exceed MAX_WAIT wait
// cycles, drives the forwarding path back to EX and registers the result
// into the WB stage.
//
// Parameters
//   MAX_WAIT              wait cycles tolerated after the issue cycle (>=1)
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   ALU_out_MEM           address for loads/stores, result otherwise
//   store_data_MEM        store data
//   d_write_enable_MEM    instruction is a store (wins over load)
//   d_load_enable_MEM     instruction is a load
//   Rd_MEM                destination register (0 = none)
//   ALU_out_MEM_backward  forwarded value to EX
//   Rd_MEM_backward       forwarded register index to EX
//   stall_MEM             freeze upstream stages this cycle
//   d_address, d_data_write, d_write_enable, d_read_enable  memory request
//   d_data_read, d_ack    memory response
//   data_WB, Rd_WB        registered write-back value / destination
//   bus_error             sticky misaligned / timeout flag
// ----------------------------------------------------------------------------
module mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ALU_out_MEM,
    input  logic [31:0] store_data_MEM,
    input  logic        d_write_enable_MEM,
    input  logic        d_load_enable_MEM,
    input  logic [4:0]  Rd_MEM,
    output logic [31:0] ALU_out_MEM_backward,
    output logic [4:0]  Rd_MEM_backward,
    output logic        stall_MEM,
    output logic [31:0] d_address,
    output logic [31:0] d_data_write,
    output logic        d_write_enable,
    output logic        d_read_enable,
    input  logic [31:0] d_data_read,
    input  logic        d_ack,
    output logic [31:0] data_WB,
    output logic [4:0]  Rd_WB,
    output logic        bus_error
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:2]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_is_store;
    logic [4:0]    r_rd;
    logic [31:0]   r_data_wb;
    logic [4:0]    r_rd_wb;
    logic          r_bus_error;

    logic          w_store_in;
    logic          w_load_in;
    logic          w_mem_in;
    logic          w_req;
    logic          w_is_store;
    logic [31:2]   w_addr;
    logic [31:0]   w_wdata;
    logic [4:0]    w_rd;
    logic          w_misalign;
    logic          w_timeout;
    logic          w_abort;
    logic          w_complete;
    logic          w_stall;
    logic [4:0]    w_fwd_rd;

    assign w_store_in = d_write_enable_MEM;
    assign w_load_in  = d_load_enable_MEM & ~d_write_enable_MEM;
    assign w_mem_in   = w_store_in | w_load_in;

    // Request source: live inputs on the issue cycle, holding registers while
    // waiting. Everything is gated by reset_n so an asynchronous reset drops
    // the request in the same cycle, even if the inputs still show an access.
    always_comb begin
        w_req      = 1'b0;
        w_is_store = 1'b0;
        w_addr     = '0;
        w_wdata    = '0;
        w_rd       = '0;
        w_misalign = 1'b0;
        w_timeout  = 1'b0;
        if (reset_n) begin
            if (r_state == S_IDLE) begin
                if (w_mem_in) begin
                    if (ALU_out_MEM[1:0] == 2'b00) begin
                        w_req      = 1'b1;
                        w_is_store = w_store_in;
                        w_addr     = ALU_out_MEM[31:2];
                        w_wdata    = store_data_MEM;
                        w_rd       = Rd_MEM;
                    end else begin
                        w_misalign = 1'b1;
                    end
                end else begin
                    w_rd = Rd_MEM;
                end
            end else begin
                w_req      = 1'b1;
                w_is_store = r_is_store;
                w_addr     = r_addr;
                w_wdata    = r_wdata;
                w_rd       = r_rd;
                w_timeout  = ~d_ack && (r_cnt == CW'(MAX_WAIT));
            end
        end
    end

    assign w_abort    = w_misalign | w_timeout;
    assign w_complete = w_req & d_ack;
    // The abort cycle releases the pipeline even though no ack arrived.
    assign w_stall    = w_req & ~d_ack & ~w_timeout;

    assign d_address      = w_req ? {w_addr, 2'b00} : 32'd0;
    assign d_data_write   = w_req ? w_wdata : 32'd0;
    assign d_write_enable = w_req & w_is_store;
    assign d_read_enable  = w_req & ~w_is_store;
    assign stall_MEM      = w_stall;

    // Only a non-memory op has its result ready here; memory ops forward r0.
    assign w_fwd_rd             = (reset_n && r_state == S_IDLE && !w_mem_in) ? Rd_MEM : 5'd0;
    assign Rd_MEM_backward      = w_fwd_rd;
    assign ALU_out_MEM_backward = (w_fwd_rd != 5'd0) ? ALU_out_MEM : 32'd0;

    // FSM, holding registers and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_store  <= 1'b0;
            r_rd        <= '0;
            r_bus_error <= 1'b0;
        end else begin
            if (w_abort) begin
                r_bus_error <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req && !d_ack) begin
                        r_state    <= S_WAIT;
                        r_cnt      <= CW'(1);
                        r_addr     <= w_addr;
                        r_wdata    <= w_wdata;
                        r_is_store <= w_is_store;
                        r_rd       <= w_rd;
                    end
                end
                S_WAIT: begin
                    if (d_ack || w_timeout) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // WB register: bubble on stall, store or abort; otherwise pass the
    // load data (on completion) or the ALU result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_wb <= '0;
            r_rd_wb   <= '0;
        end else begin
            if (w_stall || w_abort || (w_req && w_is_store)) begin
                r_rd_wb <= 5'd0;
            end else begin
                r_rd_wb   <= w_rd;
                r_data_wb <= w_complete ? d_data_read : ALU_out_MEM;
            end
        end
    end

    assign data_WB   = r_data_wb;
    assign Rd_WB     = r_rd_wb;
    assign bus_error = r_bus_error;

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
// Directed self-checking bench for mem_stage (MAX_WAIT = 15). Inputs change
// 1 ns after a rising edge; outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        reset_n;
    logic [31:0] ALU_out_MEM;
    logic [31:0] store_data_MEM;
    logic        d_write_enable_MEM;
    logic        d_load_enable_MEM;
    logic [4:0]  Rd_MEM;
    logic [31:0] ALU_out_MEM_backward;
    logic [4:0]  Rd_MEM_backward;
    logic        stall_MEM;
    logic [31:0] d_address;
    logic [31:0] d_data_write;
    logic        d_write_enable;
    logic        d_read_enable;
    logic [31:0] d_data_read;
    logic        d_ack;
    logic [31:0] data_WB;
    logic [4:0]  Rd_WB;
    logic        bus_error;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage #(.MAX_WAIT(15)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .ALU_out_MEM          (ALU_out_MEM),
        .store_data_MEM       (store_data_MEM),
        .d_write_enable_MEM   (d_write_enable_MEM),
        .d_load_enable_MEM    (d_load_enable_MEM),
        .Rd_MEM               (Rd_MEM),
        .ALU_out_MEM_backward (ALU_out_MEM_backward),
        .Rd_MEM_backward      (Rd_MEM_backward),
        .stall_MEM            (stall_MEM),
        .d_address            (d_address),
        .d_data_write         (d_data_write),
        .d_write_enable       (d_write_enable),
        .d_read_enable        (d_read_enable),
        .d_data_read          (d_data_read),
        .d_ack                (d_ack),
        .data_WB              (data_WB),
        .Rd_WB                (Rd_WB),
        .bus_error            (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] sd,
                         input logic we, input logic le, input logic [4:0] rd);
        ALU_out_MEM        = alu;
        store_data_MEM     = sd;
        d_write_enable_MEM = we;
        d_load_enable_MEM  = le;
        Rd_MEM             = rd;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        d_data_read = 32'd0;
        d_ack       = 1'b0;
        #2;
        check("rst_Rd_WB", {27'd0, Rd_WB}, 32'd0);
        check("rst_data_WB", data_WB, 32'd0);
        check("rst_bus_error", {31'd0, bus_error}, 32'd0);
        check("rst_stall", {31'd0, stall_MEM}, 32'd0);
        check("rst_rd_en", {31'd0, d_read_enable}, 32'd0);
        check("rst_addr", d_address, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // ALU pass-through
        drive(32'h1234, 32'd0, 1'b0, 1'b0, 5'd5);
        #1;
        check("alu_fwd_val", ALU_out_MEM_backward, 32'h1234);
        check("alu_fwd_rd", {27'd0, Rd_MEM_backward}, 32'd5);
        check("alu_stall", {31'd0, stall_MEM}, 32'd0);
        step();
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        check("alu_data_WB", data_WB, 32'h1234);
        check("alu_Rd_WB", {27'd0, Rd_WB}, 32'd5);

        // Load with 3 wait cycles
        drive(32'h100, 32'd0, 1'b0, 1'b1, 5'd7);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ld3_rd_en_%0d", i), {31'd0, d_read_enable}, 32'd1);
            check($sformatf("ld3_stall_%0d", i), {31'd0, stall_MEM}, 32'd1);
            check($sformatf("ld3_addr_%0d", i), d_address, 32'h100);
            check($sformatf("ld3_fwd_rd_%0d", i), {27'd0, Rd_MEM_backward}, 32'd0);
            step();
            check($sformatf("ld3_bubble_%0d", i), {27'd0, Rd_WB}, 32'd0);
        end
        d_ack       = 1'b1;
        d_data_read = 32'hDEADBEEF;
        #1;
        check("ld3_rd_en_3", {31'd0, d_read_enable}, 32'd1);
        check("ld3_stall_3", {31'd0, stall_MEM}, 32'd0);
        step();
        d_ack       = 1'b0;
        d_data_read = 32'd0;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        check("ld3_data_WB", data_WB, 32'hDEADBEEF);
        check("ld3_Rd_WB", {27'd0, Rd_WB}, 32'd7);
        #1;
        check("ld3_rd_en_after", {31'd0, d_read_enable}, 32'd0);

        // Zero-wait store
        drive(32'h204, 32'hCAFE, 1'b1, 1'b0, 5'd3);
        d_ack = 1'b1;
        #1;
        check("st_we", {31'd0, d_write_enable}, 32'd1);
        check("st_re", {31'd0, d_read_enable}, 32'd0);
        check("st_addr", d_address, 32'h204);
        check("st_wdata", d_data_write, 32'hCAFE);
        check("st_stall", {31'd0, stall_MEM}, 32'd0);
        step();
        d_ack = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        #1;
        check("st_Rd_WB", {27'd0, Rd_WB}, 32'd0);
        check("st_we_after", {31'd0, d_write_enable}, 32'd0);

        // Reset in the 2nd wait cycle of a load; first load a visible Rd_WB
        drive(32'h4444, 32'd0, 1'b0, 1'b0, 5'd12);
        step();
        drive(32'h80, 32'd0, 1'b0, 1'b1, 5'd10);
        step();
        step();
        #2;
        check("rma_rd_en_pre", {31'd0, d_read_enable}, 32'd1);
        check("rma_stall_pre", {31'd0, stall_MEM}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rma_rd_en", {31'd0, d_read_enable}, 32'd0);
        check("rma_stall", {31'd0, stall_MEM}, 32'd0);
        check("rma_Rd_WB", {27'd0, Rd_WB}, 32'd0);
        step();
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        check("rma_Rd_WB_hold", {27'd0, Rd_WB}, 32'd0);
        reset_n = 1'b1;
        step();
        drive(32'h77, 32'd0, 1'b0, 1'b0, 5'd2);
        #1;
        check("rma_next_stall", {31'd0, stall_MEM}, 32'd0);
        check("rma_next_fwd", ALU_out_MEM_backward, 32'h77);
        step();
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        check("rma_next_data_WB", data_WB, 32'h77);
        check("rma_next_Rd_WB", {27'd0, Rd_WB}, 32'd2);

        // Misaligned load, then both enables high
        drive(32'h102, 32'd0, 1'b0, 1'b1, 5'd6);
        #1;
        check("mis_re", {31'd0, d_read_enable}, 32'd0);
        check("mis_stall", {31'd0, stall_MEM}, 32'd0);
        check("mis_addr", d_address, 32'd0);
        check("mis_err_pre", {31'd0, bus_error}, 32'd0);
        step();
        check("mis_bus_error", {31'd0, bus_error}, 32'd1);
        check("mis_Rd_WB", {27'd0, Rd_WB}, 32'd0);
        drive(32'h300, 32'h5A5A, 1'b1, 1'b1, 5'd8);
        d_ack = 1'b1;
        #1;
        check("both_we", {31'd0, d_write_enable}, 32'd1);
        check("both_re", {31'd0, d_read_enable}, 32'd0);
        check("both_addr", d_address, 32'h300);
        step();
        d_ack = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        check("both_Rd_WB", {27'd0, Rd_WB}, 32'd0);

        // Timeout with MAX_WAIT = 15
        do_reset();
        check("to_err_clear", {31'd0, bus_error}, 32'd0);
        step();
        drive(32'h40, 32'd0, 1'b0, 1'b1, 5'd9);
        #1;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("to_stall_%0d", i), {31'd0, stall_MEM}, 32'd1);
            step();
            check($sformatf("to_bubble_%0d", i), {27'd0, Rd_WB}, 32'd0);
        end
        check("to_stall_15", {31'd0, stall_MEM}, 32'd0);
        check("to_rd_en_15", {31'd0, d_read_enable}, 32'd1);
        step();
        check("to_bus_error", {31'd0, bus_error}, 32'd1);
        check("to_Rd_WB", {27'd0, Rd_WB}, 32'd0);
        // spurious ack with an ALU op in flight
        drive(32'h55, 32'd0, 1'b0, 1'b0, 5'd4);
        d_ack       = 1'b1;
        d_data_read = 32'h999;
        #1;
        check("late_ack_re", {31'd0, d_read_enable}, 32'd0);
        check("late_ack_stall", {31'd0, stall_MEM}, 32'd0);
        step();
        d_ack = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        check("late_ack_data_WB", data_WB, 32'h55);
        check("late_ack_Rd_WB", {27'd0, Rd_WB}, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
